// File: rtl/inst_queue_pkg.sv
// inst_queue shared types: exception codes, queue depth and the entry record.
package inst_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef enum logic [2:0] {
        EXC_NONE,
        EXC_ADEF,
        EXC_TLBR,
        EXC_PIF,
        EXC_PPI
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_branch_taken;
        logic [31:0] pred_branch_target;
        logic        have_exception;
        exception_t  exception_type;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-to-decode bundle of the instruction queue.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic        iq_allowin;

    logic        f_a_valid;
    logic [31:0] f_a_pc;
    logic [31:0] f_a_inst;
    logic        f_a_pred_branch_taken;
    logic [31:0] f_a_pred_branch_target;
    logic        f_a_have_exception;
    exception_t  f_a_exception_type;

    logic        f_b_valid;
    logic [31:0] f_b_pc;
    logic [31:0] f_b_inst;
    logic        f_b_pred_branch_taken;
    logic [31:0] f_b_pred_branch_target;
    logic        f_b_have_exception;
    exception_t  f_b_exception_type;

    logic [1:0]  id_consume_inst;

    logic        a_valid;
    logic [31:0] a_pc;
    logic [31:0] a_inst;
    logic        a_pred_branch_taken;
    logic [31:0] a_pred_branch_target;
    logic        a_have_exception;
    exception_t  a_exception_type;

    logic        b_valid;
    logic [31:0] b_pc;
    logic [31:0] b_inst;
    logic        b_pred_branch_taken;
    logic [31:0] b_pred_branch_target;
    logic        b_have_exception;
    exception_t  b_exception_type;

    modport master (
        output f_a_valid, f_a_pc, f_a_inst, f_a_pred_branch_taken,
        output f_a_pred_branch_target, f_a_have_exception, f_a_exception_type,
        output f_b_valid, f_b_pc, f_b_inst, f_b_pred_branch_taken,
        output f_b_pred_branch_target, f_b_have_exception, f_b_exception_type,
        output id_consume_inst,
        input  iq_allowin,
        input  a_valid, a_pc, a_inst, a_pred_branch_taken,
        input  a_pred_branch_target, a_have_exception, a_exception_type,
        input  b_valid, b_pc, b_inst, b_pred_branch_taken,
        input  b_pred_branch_target, b_have_exception, b_exception_type
    );

    modport slave (
        input  f_a_valid, f_a_pc, f_a_inst, f_a_pred_branch_taken,
        input  f_a_pred_branch_target, f_a_have_exception, f_a_exception_type,
        input  f_b_valid, f_b_pc, f_b_inst, f_b_pred_branch_taken,
        input  f_b_pred_branch_target, f_b_have_exception, f_b_exception_type,
        input  id_consume_inst,
        output iq_allowin,
        output a_valid, a_pc, a_inst, a_pred_branch_taken,
        output a_pred_branch_target, a_have_exception, a_exception_type,
        output b_valid, b_pc, b_inst, b_pred_branch_taken,
        output b_pred_branch_target, b_have_exception, b_exception_type
    );

endinterface

// File: rtl/inst_queue.sv
// Two-in / two-out instruction FIFO between fetch and dual-issue decode.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    inst_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CW-1:0]    count;

    logic [PTR_W-1:0] head_b;
    logic [PTR_W-1:0] tail_b;
    logic             push_a;
    logic             push_b;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    iq_entry_t        in_a;
    iq_entry_t        in_b;
    iq_entry_t        out_a;
    iq_entry_t        out_b;

    assign head_b = head + PTR_W'(1);
    assign tail_b = tail + PTR_W'(1);

    // Room for a full pair is required even for a single push.
    assign q.iq_allowin = count <= CW'(DEPTH - 2);

    assign push_a = q.iq_allowin & q.f_a_valid;
    assign push_b = push_a & q.f_b_valid;
    assign push_n = {push_b, push_a & ~push_b};

    always_comb begin
        pop_n = 2'd0;
        unique case (1'b1)
            count == '0:      pop_n = 2'd0;
            count == CW'(1):  pop_n = {1'b0, |q.id_consume_inst};
            default:          pop_n = q.id_consume_inst[1] ? 2'd2
                                                           : q.id_consume_inst;
        endcase
    end

    assign in_a = '{
        pc:                 q.f_a_pc,
        inst:               q.f_a_inst,
        pred_branch_taken:  q.f_a_pred_branch_taken,
        pred_branch_target: q.f_a_pred_branch_target,
        have_exception:     q.f_a_have_exception,
        exception_type:     q.f_a_exception_type
    };

    assign in_b = '{
        pc:                 q.f_b_pc,
        inst:               q.f_b_inst,
        pred_branch_taken:  q.f_b_pred_branch_taken,
        pred_branch_target: q.f_b_pred_branch_target,
        have_exception:     q.f_b_have_exception,
        exception_type:     q.f_b_exception_type
    };

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_a) mem[tail]   <= in_a;
            if (push_b) mem[tail_b] <= in_b;
            tail  <= tail + PTR_W'(push_n);
            head  <= head + PTR_W'(pop_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    assign out_a = mem[head];
    assign out_b = mem[head_b];

    assign q.a_valid              = count != '0;
    assign q.a_pc                 = out_a.pc;
    assign q.a_inst               = out_a.inst;
    assign q.a_pred_branch_taken  = out_a.pred_branch_taken;
    assign q.a_pred_branch_target = out_a.pred_branch_target;
    assign q.a_have_exception     = out_a.have_exception;
    assign q.a_exception_type     = out_a.exception_type;

    assign q.b_valid              = count >= CW'(2);
    assign q.b_pc                 = out_b.pc;
    assign q.b_inst               = out_b.inst;
    assign q.b_pred_branch_taken  = out_b.pred_branch_taken;
    assign q.b_pred_branch_target = out_b.pred_branch_target;
    assign q.b_have_exception     = out_b.have_exception;
    assign q.b_exception_type     = out_b.exception_type;

    // Protocol monitors; illegal requests are clamped or dropped above.
    always @(posedge clk) begin
        if (resetn && !flush) begin
            assert (q.f_a_valid || !q.f_b_valid)
                else $warning("inst_queue: slot b valid without slot a");
            assert (q.iq_allowin || !q.f_a_valid)
                else $warning("inst_queue: push while full dropped");
            assert (q.id_consume_inst != 2'd3
                    && CW'(q.id_consume_inst) <= count)
                else $warning("inst_queue: consume count clamped");
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected entries queued on push, popped on consume.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic clk;
    logic resetn;
    logic flush;

    inst_queue_if qi ();

    inst_queue #(.DEPTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .q      (qi)
    );

    always #5 clk = ~clk;

    iq_entry_t   exp_q[$];
    int          errors;
    int          checks;
    logic [31:0] next_pc;

    function automatic iq_entry_t make(input logic [31:0] pc);
        iq_entry_t e;
        e.pc                 = pc;
        e.inst               = pc ^ 32'h0280_0013;
        e.pred_branch_taken  = pc[2];
        e.pred_branch_target = pc + 32'h40;
        e.have_exception     = pc[4];
        e.exception_type     = pc[4] ? EXC_ADEF : EXC_NONE;
        return e;
    endfunction

    function automatic iq_entry_t obs_a();
        return '{qi.a_pc, qi.a_inst, qi.a_pred_branch_taken,
                 qi.a_pred_branch_target, qi.a_have_exception,
                 qi.a_exception_type};
    endfunction

    function automatic iq_entry_t obs_b();
        return '{qi.b_pc, qi.b_inst, qi.b_pred_branch_taken,
                 qi.b_pred_branch_target, qi.b_have_exception,
                 qi.b_exception_type};
    endfunction

    // Drive one cycle from a negedge, update the scoreboard, return at the next negedge.
    task automatic drive(input bit av, input bit bv,
                         input logic [1:0] cons, input bit fl);
        iq_entry_t ea;
        iq_entry_t eb;
        int        c;
        bit        room;
        ea = make(next_pc);
        eb = make(next_pc + 32'd4);
        qi.f_a_valid              = av;
        qi.f_a_pc                 = ea.pc;
        qi.f_a_inst               = ea.inst;
        qi.f_a_pred_branch_taken  = ea.pred_branch_taken;
        qi.f_a_pred_branch_target = ea.pred_branch_target;
        qi.f_a_have_exception     = ea.have_exception;
        qi.f_a_exception_type     = ea.exception_type;
        qi.f_b_valid              = bv;
        qi.f_b_pc                 = eb.pc;
        qi.f_b_inst               = eb.inst;
        qi.f_b_pred_branch_taken  = eb.pred_branch_taken;
        qi.f_b_pred_branch_target = eb.pred_branch_target;
        qi.f_b_have_exception     = eb.have_exception;
        qi.f_b_exception_type     = eb.exception_type;
        qi.id_consume_inst        = cons;
        flush                     = fl;
        @(posedge clk);
        room = (8 - exp_q.size()) >= 2;
        if (fl) begin
            exp_q.delete();
        end else begin
            c = (cons == 2'd3) ? 2 : int'(cons);
            if (c > exp_q.size()) c = exp_q.size();
            repeat (c) void'(exp_q.pop_front());
            if (room && av) begin
                exp_q.push_back(ea);
                next_pc += 32'd4;
                if (bv) begin
                    exp_q.push_back(eb);
                    next_pc += 32'd4;
                end
            end
        end
        @(negedge clk);
        qi.f_a_valid       = 1'b0;
        qi.f_b_valid       = 1'b0;
        qi.id_consume_inst = 2'd0;
        flush              = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (qi.a_valid !== 1'b0 || qi.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got a=%b b=%b want 0 0", qi.a_valid, qi.b_valid);
        end
        checks++;
        if (qi.iq_allowin !== 1'b1) begin
            errors++;
            $display("FAIL reset_allowin got %b want 1", qi.iq_allowin);
        end
        checks++;
        if (qi.a_pc !== 32'h0 || qi.b_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got a=%h b=%h want 0 0", qi.a_pc, qi.b_pc);
        end
        resetn = 1'b1;
        drive(0, 0, 2'd0, 0);
        checks++;
        if (qi.a_valid !== 1'b0 || qi.iq_allowin !== 1'b1) begin
            errors++;
            $display("FAIL idle got a_valid=%b allowin=%b want 0 1", qi.a_valid, qi.iq_allowin);
        end
    endtask

    task automatic test_basic();
        drive(1, 1, 2'd0, 0);
        checks++;
        if (qi.a_valid !== 1'b1 || obs_a() !== exp_q[0] || exp_q[0].pc !== 32'h1c00_0000) begin
            errors++;
            $display("FAIL basic_a got pc=%h valid=%b want pc=1c000000", qi.a_pc, qi.a_valid);
        end
        checks++;
        if (qi.b_valid !== 1'b1 || obs_b() !== exp_q[1] || exp_q[1].pc !== 32'h1c00_0004) begin
            errors++;
            $display("FAIL basic_b got pc=%h valid=%b want pc=1c000004", qi.b_pc, qi.b_valid);
        end
        drive(0, 0, 2'd1, 0);
        checks++;
        if (qi.a_valid !== 1'b1 || qi.a_pc !== 32'h1c00_0004 || qi.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop1 got a_pc=%h b_valid=%b want 1c000004 0", qi.a_pc, qi.b_valid);
        end
        drive(0, 0, 2'd1, 0);
        checks++;
        if (qi.a_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty got a_valid=%b want 0", qi.a_valid);
        end
    endtask

    task automatic test_fill();
        repeat (3) drive(1, 1, 2'd0, 0);
        checks++;
        if (qi.iq_allowin !== 1'b1 || exp_q.size() != 6) begin
            errors++;
            $display("FAIL fill6_allowin got %b want 1 (size %0d)", qi.iq_allowin, exp_q.size());
        end
        drive(1, 1, 2'd0, 0);
        checks++;
        if (qi.iq_allowin !== 1'b0) begin
            errors++;
            $display("FAIL fill8_allowin got %b want 0", qi.iq_allowin);
        end
        drive(1, 1, 2'd0, 0);
        checks++;
        if (qi.iq_allowin !== 1'b0 || obs_a() !== exp_q[0] || exp_q.size() != 8) begin
            errors++;
            $display("FAIL fill_drop got a_pc=%h want %h", qi.a_pc, exp_q[0].pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_a() !== exp_q[0] || obs_b() !== exp_q[1] || qi.b_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_%0d got a=%h b=%h want %h %h", i, qi.a_pc, qi.b_pc, exp_q[0].pc, exp_q[1].pc);
            end
            drive(0, 0, 2'd2, 0);
        end
        checks++;
        if (qi.a_valid !== 1'b0 || qi.iq_allowin !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got a_valid=%b allowin=%b want 0 1", qi.a_valid, qi.iq_allowin);
        end
    endtask

    task automatic test_single();
        drive(1, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (qi.a_valid !== 1'b1 || obs_a() !== exp_q[0] || qi.b_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_%0d got a_pc=%h b_valid=%b want %h 0", i, qi.a_pc, qi.b_valid, exp_q[0].pc);
            end
            drive(1, 0, 2'd1, 0);
        end
        drive(0, 0, 2'd2, 0);
        checks++;
        if (qi.a_valid !== 1'b0 || qi.b_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clamp got a_valid=%b b_valid=%b want 0 0", qi.a_valid, qi.b_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 2'd0, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (qi.a_valid !== 1'b1 || qi.b_valid !== 1'b1
                || obs_a() !== exp_q[0] || obs_b() !== exp_q[1]) begin
                errors++;
                $display("FAIL b2b_%0d got a=%h b=%h want %h %h", i, qi.a_pc, qi.b_pc, exp_q[0].pc, exp_q[1].pc);
            end
            drive(1, 1, 2'd2, 0);
        end
        checks++;
        if (qi.b_pc !== qi.a_pc + 32'd4 || obs_b() !== exp_q[1]) begin
            errors++;
            $display("FAIL b2b_order got a=%h b=%h want b=%h", qi.a_pc, qi.b_pc, exp_q[1].pc);
        end
        drive(0, 0, 2'd2, 0);
    endtask

    task automatic test_flush();
        drive(1, 1, 2'd0, 0);
        drive(1, 1, 2'd0, 0);
        drive(1, 0, 2'd0, 0);
        checks++;
        if (exp_q.size() != 5 || obs_a() !== exp_q[0]) begin
            errors++;
            $display("FAIL pre_flush got a_pc=%h want %h", qi.a_pc, exp_q[0].pc);
        end
        drive(1, 1, 2'd1, 1);
        checks++;
        if (qi.a_valid !== 1'b0 || qi.b_valid !== 1'b0 || qi.iq_allowin !== 1'b1) begin
            errors++;
            $display("FAIL flush got a=%b b=%b allowin=%b want 0 0 1", qi.a_valid, qi.b_valid, qi.iq_allowin);
        end
        drive(1, 0, 2'd0, 0);
        checks++;
        if (qi.a_valid !== 1'b1 || obs_a() !== exp_q[0] || qi.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_flush got a_pc=%h want %h", qi.a_pc, exp_q[0].pc);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 2'd0, 0);
        qi.f_a_valid       = 1'b1;
        qi.f_b_valid       = 1'b1;
        qi.id_consume_inst = 2'd1;
        #2 resetn = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (qi.a_valid !== 1'b0 || qi.iq_allowin !== 1'b1 || qi.a_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got a_valid=%b allowin=%b a_pc=%h want 0 1 0", qi.a_valid, qi.iq_allowin, qi.a_pc);
        end
        qi.f_a_valid       = 1'b0;
        qi.f_b_valid       = 1'b0;
        qi.id_consume_inst = 2'd0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        clk     = 1'b0;
        resetn  = 1'b0;
        flush   = 1'b0;
        errors  = 0;
        checks  = 0;
        next_pc = 32'h1c00_0000;
        qi.f_a_valid       = 1'b0;
        qi.f_b_valid       = 1'b0;
        qi.id_consume_inst = 2'd0;
        test_reset();
        test_basic();
        test_fill();
        test_single();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
